// File: rtl/desired_drive_seq.sv
// rtl/desired_drive_seq.sv - sequenced eBike assist-current computation on one shared multiplier
module desired_drive_seq #(
    parameter logic [11:0] TORQUE_MIN = 12'h380
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [11:0] avg_torque_i,
    input  logic [4:0]  cadence_i,
    input  logic        not_pedaling_i,
    input  logic [12:0] incline_i,
    input  logic [2:0]  scale_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [11:0] target_curr_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FACT = 3'd1,
        MUL1 = 3'd2,
        MUL2 = 3'd3,
        MUL3 = 3'd4,
        OUT  = 3'd5
    } state_t;

    state_t state_q, state_d;

    // Inputs captured on an accepted start; only these are used afterwards.
    logic [11:0]        avg_torque_q;
    logic [4:0]         cadence_q;
    logic               not_pedaling_q;
    logic signed [12:0] incline_q;
    logic [2:0]         scale_q;

    // Derived factors, registered in FACT.
    logic [11:0] torque_pos_q, torque_pos_d;
    logic [8:0]  incline_lim_q, incline_lim_d;
    logic [5:0]  cadence_factor_q, cadence_factor_d;

    logic [29:0] acc_q, acc_d;
    logic [11:0] target_q, target_d;
    logic        done_q;

    logic signed [9:0] incline_sat;
    logic [10:0]       incline_factor;
    logic [12:0]       torque_diff;

    logic [26:0] mul_a;
    logic [8:0]  mul_b;
    logic [29:0] mul_p;

    // Factor derivation from the captured inputs.
    always_comb begin
        if (incline_q > 13'sd511) begin
            incline_sat = 10'sh1FF;
        end else if (incline_q < -13'sd512) begin
            incline_sat = 10'sh200;
        end else begin
            incline_sat = incline_q[9:0];
        end

        incline_factor = {incline_sat[9], incline_sat} + 11'd256;

        if (incline_factor[10]) begin
            incline_lim_d = 9'd0;
        end else if (incline_factor[9]) begin
            incline_lim_d = 9'd511;
        end else begin
            incline_lim_d = incline_factor[8:0];
        end

        if (cadence_q > 5'd1) begin
            cadence_factor_d = {1'b0, cadence_q} + 6'd32;
        end else begin
            cadence_factor_d = 6'd0;
        end

        torque_diff = {1'b0, avg_torque_q} - {1'b0, TORQUE_MIN};
        torque_pos_d = torque_diff[12] ? 12'd0 : torque_diff[11:0];
    end

    // Operand selection for the shared multiplier; the product never exceeds 30 bits.
    always_comb begin
        mul_a = 27'd0;
        mul_b = 9'd0;
        case (state_q)
            MUL1: begin
                mul_a = {15'd0, torque_pos_q};
                mul_b = incline_lim_q;
            end
            MUL2: begin
                mul_a = acc_q[26:0];
                mul_b = {3'd0, cadence_factor_q};
            end
            MUL3: begin
                mul_a = acc_q[26:0];
                mul_b = {6'd0, scale_q};
            end
            default: begin
                mul_a = 27'd0;
                mul_b = 9'd0;
            end
        endcase
        mul_p = {3'd0, mul_a} * {21'd0, mul_b};
    end

    // Next-state, accumulator and result selection.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        target_d = target_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = FACT;
                end
            end
            FACT: begin
                if (not_pedaling_q) begin
                    acc_d   = 30'd0;
                    state_d = OUT;
                end else begin
                    state_d = MUL1;
                end
            end
            MUL1: begin
                acc_d   = mul_p;
                state_d = MUL2;
            end
            MUL2: begin
                acc_d   = mul_p;
                state_d = MUL3;
            end
            MUL3: begin
                acc_d   = mul_p;
                state_d = OUT;
            end
            OUT: begin
                target_d = (|acc_q[29:27]) ? 12'hFFF : acc_q[26:15];
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath registers and the registered done pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= IDLE;
            acc_q            <= 30'd0;
            target_q         <= 12'd0;
            done_q           <= 1'b0;
            avg_torque_q     <= 12'd0;
            cadence_q        <= 5'd0;
            not_pedaling_q   <= 1'b0;
            incline_q        <= 13'sd0;
            scale_q          <= 3'd0;
            torque_pos_q     <= 12'd0;
            incline_lim_q    <= 9'd0;
            cadence_factor_q <= 6'd0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            target_q <= target_d;
            done_q   <= (state_q == OUT);
            if (state_q == IDLE && start_i) begin
                avg_torque_q   <= avg_torque_i;
                cadence_q      <= cadence_i;
                not_pedaling_q <= not_pedaling_i;
                incline_q      <= incline_i;
                scale_q        <= scale_i;
            end
            if (state_q == FACT) begin
                torque_pos_q     <= torque_pos_d;
                incline_lim_q    <= incline_lim_d;
                cadence_factor_q <= cadence_factor_d;
            end
        end
    end

    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign target_curr_o = target_q;

endmodule

// File: tb/tb_desired_drive_seq.sv
// tb/tb_desired_drive_seq.sv - directed self-checking bench for desired_drive_seq
module tb_desired_drive_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] avg_torque;
    logic [4:0]  cadence;
    logic        not_pedaling;
    logic [12:0] incline;
    logic [2:0]  scale;
    logic        busy;
    logic        done;
    logic [11:0] target_curr;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    desired_drive_seq #(.TORQUE_MIN(12'h380)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .avg_torque_i   (avg_torque),
        .cadence_i      (cadence),
        .not_pedaling_i (not_pedaling),
        .incline_i      (incline),
        .scale_i        (scale),
        .busy_o         (busy),
        .done_o         (done),
        .target_curr_o  (target_curr)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [11:0] t, input logic [12:0] inc, input logic [4:0] c,
                          input logic [2:0] s, input logic np);
        avg_torque   = t;
        incline      = inc;
        cadence      = c;
        scale        = s;
        not_pedaling = np;
    endtask

    task automatic issue(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy after start"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input string tag, input int lat0, input int exp_lat,
                             input logic [11:0] exp_val);
        int lat;
        lat = lat0;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat = lat + 1;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " target"}, {20'd0, target_curr}, {20'd0, exp_val});
        check({tag, " busy in done cycle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run(input string tag, input int exp_lat, input logic [11:0] exp_val);
        issue(tag);
        wait_done(tag, 1, exp_lat, exp_val);
    endtask

    task automatic count_dones(input string tag, input int cycles);
        int n;
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done === 1'b1) n = n + 1;
        end
        check({tag, " no extra done"}, n, 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        set_in(12'h0, 13'h0, 5'd0, 3'd0, 1'b0);
        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset target", {20'd0, target_curr}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1024 * 256 * 48 * 4 = 50,331,648 -> bits [26:15] = 0x600
        set_in(12'h780, 13'h0000, 5'd16, 3'd4, 1'b0);
        run("nominal", 6, 12'h600);
        repeat (3) @(negedge clk);
        check("hold while idle", {20'd0, target_curr}, 32'h600);

        set_in(12'h780, 13'h0000, 5'd16, 3'd4, 1'b1);
        run("not_pedaling", 3, 12'h000);
        @(negedge clk);

        // 3199 * 511 * 63 * 7 = 720,897,849 >= 2^27 -> saturate
        set_in(12'hFFF, 13'h0FFF, 5'd31, 3'd7, 1'b0);
        run("saturation", 6, 12'hFFF);
        @(negedge clk);

        set_in(12'h300, 13'h0000, 5'd16, 3'd4, 1'b0);
        run("torque clamp", 6, 12'h000);
        @(negedge clk);
        set_in(12'h780, 13'h1ED4, 5'd16, 3'd4, 1'b0);
        run("incline clamp", 6, 12'h000);
        @(negedge clk);
        set_in(12'h780, 13'h0000, 5'd1, 3'd4, 1'b0);
        run("cadence clamp", 6, 12'h000);
        @(negedge clk);

        // incline -100: factor 156; 1024 * 156 * 48 * 4 = 30,670,848 -> 0x3A8
        set_in(12'h780, 13'h1F9C, 5'd16, 3'd4, 1'b0);
        run("incline -100", 6, 12'h3A8);
        // start in the done cycle is accepted
        set_in(12'hFFF, 13'h0FFF, 5'd31, 3'd7, 1'b0);
        run("back to back", 6, 12'hFFF);
        @(negedge clk);

        // start while busy is ignored, not queued
        set_in(12'h780, 13'h0000, 5'd16, 3'd4, 1'b0);
        issue("busy start");
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy start", 4, 6, 12'h600);
        count_dones("busy start", 10);

        // inputs changed after capture do not affect the result
        set_in(12'h780, 13'h1F9C, 5'd16, 3'd4, 1'b0);
        issue("scramble");
        set_in(12'h000, 13'h0000, 5'd0, 3'd0, 1'b1);
        wait_done("scramble", 1, 6, 12'h3A8);
        @(negedge clk);

        // reset during MUL2 discards the computation
        set_in(12'h780, 13'h0000, 5'd16, 3'd4, 1'b0);
        issue("mid reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid reset busy", {31'd0, busy}, 32'd0);
        check("mid reset done", {31'd0, done}, 32'd0);
        check("mid reset target", {20'd0, target_curr}, 32'd0);
        count_dones("mid reset", 8);
        run("after reset", 6, 12'h600);
        @(negedge clk);

        // reset wins over a simultaneous start
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst with start busy", {31'd0, busy}, 32'd0);
        check("rst with start target", {20'd0, target_curr}, 32'd0);
        count_dones("rst with start", 8);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/desired_drive_seq.md
# desired_drive_seq

Sequenced, resource-shared implementation of the eBike assist-current computation. On a `start` pulse it captures the rider and sensor inputs and derives the torque, incline and cadence factors. It then forms the four-way assist product on one shared unsigned multiplier over three cycles, and saturates and scales the result into `target_curr`. It sits between the sensor conditioning logic and the motor current loop, and replaces the fully parallel multiplier chain with an area-reduced, start/done handshaked datapath.

## Interface
- `TORQUE_MIN`, default 12'h380: torque offset subtracted from `avg_torque`.
- `clk` input 1: system clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a computation; sampled only in IDLE.
- `avg_torque` input 12: unsigned filtered crank torque.
- `cadence` input 5: unsigned cadence.
- `not_pedaling` input 1: forces a zero result.
- `incline` input 13: signed incline.
- `scale` input 3: unsigned assist level.
- `busy` output 1: high from the cycle after `start` is accepted until the cycle `done` rises.
- `done` output 1: single-cycle pulse; `target_curr` is valid and updated in this cycle.
- `target_curr` output 12: unsigned motor current target; holds its value between computations.

## Operation
- States: IDLE, FACT, MUL1, MUL2, MUL3, OUT.
- **IDLE:** if `start`=1, register all data inputs and go to FACT. Otherwise stay.
- **FACT:** register the derived factors.
  - `incline_sat`: `incline` saturated to 10-bit signed. Above 511 gives 511; below −512 gives −512.
  - `incline_factor` = sign-extended `incline_sat` + 256, 11-bit signed.
  - `incline_lim` (9b): 0 if `incline_factor` < 0; 511 if `incline_factor` > 511; otherwise `incline_factor`.
  - `cadence_factor` (6b): `cadence`+32 if `cadence` > 1, else 0.
  - `torque_pos` (12b): `avg_torque` − `TORQUE_MIN` computed at 13 bits; 0 if negative.
  - Next state is MUL1, or OUT with `acc` cleared to 0 if the captured `not_pedaling`=1.
- **Shared multiplier:** one unsigned multiplier, 27-bit A × 9-bit B, with a 30-bit accumulator `acc`. Operands are muxed by state.
  - MUL1: `acc` = `torque_pos` × `incline_lim`.
  - MUL2: `acc` = `acc` × `cadence_factor`.
  - MUL3: `acc` = `acc` × `scale`.
- **No overflow:** the maximum value is 4095×511×63×7 < 2^30, so no intermediate truncation occurs.
- **OUT:** `target_curr` ← 12'hFFF if any of `acc[29:27]` is set, else `acc[26:15]`. Assert `done` and go to IDLE.
- **Start while not IDLE:** ignored, not queued.

## Timing
- Let k be the edge where `start` is sampled in IDLE.
- Full path: FACT at k, MUL1 at k+1, MUL2 at k+2, MUL3 at k+3, OUT at k+4.
  - `target_curr` updates and `done`=1 in the cycle after edge k+5. Latency is 6 clocks.
- `not_pedaling` path: `done` is high after edge k+2. Latency is 3 clocks.
- `done` is registered and high exactly one cycle. In that cycle the state is IDLE and `busy`=0.
  - A `start` sampled with `done` high is accepted, giving a back-to-back throughput of one result per 6 clocks.
- `busy` is high from edge k until the edge that raises `done`.
- Inputs may change freely after edge k; only the captured values are used.
- **Reset (any state, including mid-computation):** at the next edge the state is IDLE and `busy`=0, `done`=0, `target_curr`=0, `acc`=0. Any in-flight computation is discarded with no `done`. If `rst` and `start` are high together, reset wins.

## Test plan
- **Reset values:** assert `rst` for 2 cycles. Expect `busy`=0, `done`=0, `target_curr`=0. Pulse `rst` during MUL2: expect no `done`, `target_curr`=0, and the next `start` computes normally.
- **Nominal:** `avg_torque`=0x780, `incline`=0, `cadence`=16, `scale`=4, `not_pedaling`=0. Expect `done` exactly 6 clocks after start and `target_curr`=0x600 (product 50,331,648).
- **Not pedaling:** same inputs with `not_pedaling`=1. Expect `done` 3 clocks after start and `target_curr`=0.
- **Saturation:** `avg_torque`=0xFFF, `incline`=13'h0FFF, `cadence`=31, `scale`=7. Expect `incline_lim`=511, `cadence_factor`=63, product 720,897,849, and `target_curr`=0xFFF.
- **Zero clamps, each run separately with the other inputs nominal:**
  - `avg_torque`=0x300
  - `incline`=−300 (13'h1ED4, so `incline_factor`=−44)
  - `cadence`=1
  - Each gives `target_curr`=0 with the full 6-clock latency.
- **Handshake:**
  - Start during `busy`: ignored, single `done`.
  - Start in the `done` cycle: accepted, second `done` 6 clocks later.
  - Change inputs after capture: result unaffected.
  - `target_curr` holds its value while IDLE.
